rle_stream_encoder: RTL and testbench
=====================================

// Module: rle_stream_encoder
// PURPOSE
//  Parametrised run-length encoder for one zig-zag-ordered coefficient stream.
//  It follows the zig-zag stage and feeds the Huffman/entropy packer.
//  Coefficient 0 of each block (DC) passes through unchanged.
//  AC zeros become JPEG (run, value) symbols, with ZRL for runs of 16 and EOB for trailing zeros.
//  Valid/ready on both sides; instantiate once per channel (Y, Cb, Cr).
// PARAMETERS
//  COEF_W     11   signed coefficient width in bits
//  BLOCK_LEN  64   coefficients per block (power of 2, >=2)
//  IDX_W      $clog2(BLOCK_LEN)   index/run counter width (derived, do not override)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  in_coef    in   COEF_W     coefficient, zig-zag order, two's complement
//  in_valid   in   1          in_coef valid
//  in_ready   out  1          encoder accepts in_coef this cycle
//  out_sym    out  4+COEF_W   {run[3:0], value[COEF_W-1:0]}
//  out_dc     out  1          out_sym is the DC word of a block
//  out_last   out  1          out_sym is the final symbol of a block
//  out_valid  out  1          out_sym/out_dc/out_last valid
//  out_ready  in   1          sink accepts output this cycle
// BEHAVIOUR
//  Reset (asynchronous, any time): out_sym=0, out_dc=0, out_last=0, out_valid=0.
//   Also clears idx=0, run=0, hold=0 and state=ACCEPT. A partial block is discarded.
//  Output register is a single stage.
//   It is free when !out_valid || out_ready.
//   out_* stay stable while out_valid && !out_ready.
//  in_ready = (state==ACCEPT) && free.
//   An input is accepted when in_valid && in_ready.
//  Latency: an emitted symbol appears on out_* 1 cycle after the accept or emit edge.
//  idx increments on each accept and wraps from BLOCK_LEN-1 to 0 (next block).
//  State ACCEPT, on accept at index idx:
//   - idx==0: emit {4'h0, coef}, out_dc=1, run=0. Zero DC is still emitted.
//   - AC, coef==0, idx<BLOCK_LEN-1: run=run+1; no output.
//   - AC, coef==0, idx==BLOCK_LEN-1: emit EOB {4'h0,0}, out_last=1, run=0.
//   - AC, coef!=0, run<16: emit {run[3:0], coef}, out_last=(idx==BLOCK_LEN-1), run=0.
//   - AC, coef!=0, run>=16: emit ZRL {4'hF,0}, run=run-16, hold=coef.
//     hold_last=(idx==BLOCK_LEN-1); go to ZRL.
//  State ZRL (in_ready=0), on each free cycle:
//   - run>=16: emit another ZRL, run=run-16.
//   - else: emit {run[3:0], hold}, out_last=hold_last, run=0; go to ACCEPT.
//  ZRL words are never emitted for trailing zeros; EOB replaces them.
//  No EOB is emitted when the last coefficient is nonzero.
//  Max ZRLs per symbol = floor((BLOCK_LEN-2)/16), i.e. 3 for 64.
//  out_dc and out_last are 0 on all other words.
//  out_valid drops after a transfer unless a new symbol is emitted the same cycle, so back-to-back throughput is 1 per cycle.
//  in_valid low is a bubble: no state change, run is preserved.
// TESTING
//  1. DC=5, AC1..63=0 -> {0,5} dc=1; then {0,0} last=1. Exactly 2 words.
//  2. DC=0, AC1=3, rest 0 -> {0,0} dc=1; {0,3}; {0,0} last=1.
//  3. DC=1, AC1..20=0, AC21=-7, rest 0 -> {0,1}; {F,0}; {4,-7}; EOB last=1.
//     in_ready low for 1 cycle.
//  4. DC=2, AC1..47=0, AC48=6, AC49..62=0, AC63=9 -> {0,2}; {F,0}; {F,0}; {F,6}; {E,9} last=1.
//     No EOB.
//  5. Repeat case 4 with out_ready low 10 cycles mid-ZRL -> out_* held stable, in_ready=0.
//     Identical word sequence, no loss or duplication. Then two back-to-back blocks with no gap.
//  6. Assert reset asynchronously after 30 coefs -> all outputs 0 immediately.
//     Next block encodes as case 1 from idx 0.

Source files
------------

// File: rtl/rle_stream_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rle_stream_encoder_if                                      |
// | Brief   : Coefficient-in / symbol-out handshake bundle for the RLE.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rle_stream_encoder_if #(
  parameter int COEF_W = 11
);
  logic [COEF_W-1:0] in_coef;
  logic              in_valid;
  logic              in_ready;
  logic [3+COEF_W:0] out_sym;
  logic              out_dc;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  // master: the environment feeding coefficients and sinking symbols
  modport master (
    output in_coef, in_valid, out_ready,
    input  in_ready, out_sym, out_dc, out_last, out_valid
  );

  // slave: the encoder itself
  modport slave (
    input  in_coef, in_valid, out_ready,
    output in_ready, out_sym, out_dc, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/rle_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rle_stream_encoder                                         |
// | Brief   : JPEG-style (run, value) encoder for zig-zag coefficients.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rle_stream_encoder #(
  parameter  int COEF_W    = 11,
  parameter  int BLOCK_LEN = 64,
  localparam int IDX_W     = $clog2(BLOCK_LEN)
) (
  input wire                  clk,
  input wire                  reset,
  rle_stream_encoder_if.slave bus
);

  localparam int                RUN_EXT_W   = IDX_W + 5;
  localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(BLOCK_LEN - 1);
  localparam logic [IDX_W-1:0]  c_ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0]  c_IDX_ZERO  = '0;
  localparam logic [RUN_EXT_W-1:0] c_ZRL_RUN = RUN_EXT_W'(16);
  localparam logic [COEF_W-1:0] c_ZERO_COEF = '0;
  localparam logic [3+COEF_W:0] c_ZRL_SYM   = {4'hF, c_ZERO_COEF};
  localparam logic [3+COEF_W:0] c_EOB_SYM   = {4'h0, c_ZERO_COEF};

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_ZRL    = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_run;
  logic [COEF_W-1:0] r_hold;
  logic              r_hold_last;
  logic [3+COEF_W:0] r_sym;
  logic              r_dc;
  logic              r_last;
  logic              r_valid;

  logic                 w_free;
  logic                 w_accept;
  logic                 w_is_dc;
  logic                 w_is_last;
  logic                 w_coef_zero;
  logic                 w_run_ge16;
  logic [RUN_EXT_W-1:0] w_run_ext;
  logic [IDX_W-1:0]     w_run_minus16;
  logic [3:0]           w_run_nib;

  assign w_free        = !r_valid || bus.out_ready;
  assign bus.in_ready  = (r_state == ST_ACCEPT) && w_free;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_is_dc       = (r_idx == c_IDX_ZERO);
  assign w_is_last     = (r_idx == c_LAST_IDX);
  assign w_coef_zero   = (bus.in_coef == c_ZERO_COEF);

  // Widened run so the >=16 test and the 4-bit run field are legal for tiny blocks too
  assign w_run_ext     = {5'b00000, r_run};
  assign w_run_ge16    = (w_run_ext >= c_ZRL_RUN);
  assign w_run_minus16 = r_run - c_ZRL_RUN[IDX_W-1:0];
  assign w_run_nib     = w_run_ext[3:0];

  assign bus.out_sym   = r_sym;
  assign bus.out_dc    = r_dc;
  assign bus.out_last  = r_last;
  assign bus.out_valid = r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ACCEPT;
      r_idx       <= '0;
      r_run       <= '0;
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_sym       <= '0;
      r_dc        <= 1'b0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      // A transferred word retires unless a new symbol overwrites it below
      if (w_free) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_ACCEPT: begin
          if (w_accept) begin
            r_idx <= r_idx + c_ONE;
            if (w_is_dc) begin
              r_sym   <= {4'h0, bus.in_coef};
              r_dc    <= 1'b1;
              r_last  <= 1'b0;
              r_valid <= 1'b1;
              r_run   <= '0;
            end else if (w_coef_zero) begin
              if (w_is_last) begin
                r_sym   <= c_EOB_SYM;
                r_dc    <= 1'b0;
                r_last  <= 1'b1;
                r_valid <= 1'b1;
                r_run   <= '0;
              end else begin
                r_run <= r_run + c_ONE;
              end
            end else if (!w_run_ge16) begin
              r_sym   <= {w_run_nib, bus.in_coef};
              r_dc    <= 1'b0;
              r_last  <= w_is_last;
              r_valid <= 1'b1;
              r_run   <= '0;
            end else begin
              // Park the nonzero value while the run is drained in chunks of 16
              r_sym       <= c_ZRL_SYM;
              r_dc        <= 1'b0;
              r_last      <= 1'b0;
              r_valid     <= 1'b1;
              r_run       <= w_run_minus16;
              r_hold      <= bus.in_coef;
              r_hold_last <= w_is_last;
              r_state     <= ST_ZRL;
            end
          end
        end

        ST_ZRL: begin
          if (w_free) begin
            if (w_run_ge16) begin
              r_sym   <= c_ZRL_SYM;
              r_dc    <= 1'b0;
              r_last  <= 1'b0;
              r_valid <= 1'b1;
              r_run   <= w_run_minus16;
            end else begin
              r_sym   <= {w_run_nib, r_hold};
              r_dc    <= 1'b0;
              r_last  <= r_hold_last;
              r_valid <= 1'b1;
              r_run   <= '0;
              r_state <= ST_ACCEPT;
            end
          end
        end

        default: begin
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rle_stream_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rle_stream_encoder                                      |
// | Brief   : Scoreboard bench for rle_stream_encoder.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rle_stream_encoder;

  localparam int COEF_W    = 11;
  localparam int BLOCK_LEN = 64;
  localparam int SYM_W     = 4 + COEF_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rle_stream_encoder_if #(.COEF_W(COEF_W)) bus ();

  rle_stream_encoder #(
    .COEF_W    (COEF_W),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int ir_low  = 0;
  int stim[$];
  logic [SYM_W+1:0] exp_q[$];
  int blk[BLOCK_LEN];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder working on a whole block (or its first n coefficients)
  task automatic add_block(input int c[BLOCK_LEN], input int n);
    int run;
    run = 0;
    for (int i = 0; i < n; i++) stim.push_back(c[i]);
    exp_q.push_back({4'h0, COEF_W'(c[0]), 2'b10});
    for (int i = 1; i < n; i++) begin
      if (c[i] == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back({4'hF, {COEF_W{1'b0}}, 2'b00});
          run -= 16;
        end
        exp_q.push_back({4'(run), COEF_W'(c[i]), 1'b0, (i == BLOCK_LEN - 1)});
        run = 0;
      end
    end
    if (n == BLOCK_LEN && c[BLOCK_LEN-1] == 0)
      exp_q.push_back({4'h0, {COEF_W{1'b0}}, 2'b01});
  endtask

  task automatic clear_blk();
    foreach (blk[i]) blk[i] = 0;
  endtask

  task automatic drive();
    int t;
    foreach (stim[k]) begin
      t = 0;
      bus.in_coef  = COEF_W'(stim[k]);
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (t >= 200) check("accept_timeout", 64'(t), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    stim.delete();
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every transfer must match the head of the scoreboard
  always @(negedge clk) begin
    logic [SYM_W+1:0] w;
    if (!reset && bus.in_valid && !bus.in_ready) ir_low++;
    if (!reset && bus.out_valid && bus.out_ready) begin
      check("word_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("word", {bus.out_sym, bus.out_dc, bus.out_last}, w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_coef   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_sym",   bus.out_sym,   0);
    check("rst_dc",    bus.out_dc,    0);
    check("rst_last",  bus.out_last,  0);
    check("rst_valid", bus.out_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: DC only
    clear_blk(); blk[0] = 5;
    add_block(blk, BLOCK_LEN); drive(); drain("case1");

    // 2: zero DC, single AC
    clear_blk(); blk[1] = 3;
    add_block(blk, BLOCK_LEN); drive(); drain("case2");

    // 3: one ZRL then value
    clear_blk(); blk[0] = 1; blk[21] = -7;
    ir_low = 0;
    add_block(blk, BLOCK_LEN); drive(); drain("case3");
    check("case3_in_ready_low", 64'(ir_low), 64'd1);

    // 4: two ZRLs, nonzero final coefficient, no EOB
    clear_blk(); blk[0] = 2; blk[48] = 6; blk[63] = 9;
    ir_low = 0;
    add_block(blk, BLOCK_LEN); drive(); drain("case4");
    check("case4_in_ready_low", 64'(ir_low), 64'd2);

    // 5: same block with a sink stall in the middle of the ZRL burst
    add_block(blk, BLOCK_LEN);
    fork
      drive();
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_sym == {4'hF, {COEF_W{1'b0}}}) && t < 500) begin
          t++;
          @(negedge clk);
        end
        if (t >= 500) check("case5_zrl_timeout", 64'(t), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check("case5_hold_sym",   bus.out_sym, {4'hF, {COEF_W{1'b0}}});
          check("case5_hold_valid", 64'(bus.out_valid), 64'd1);
          check("case5_hold_last",  64'(bus.out_last), 64'd0);
          check("case5_in_ready",   64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("case5");

    // Two back-to-back blocks, no idle gap between them
    clear_blk(); blk[1] = 3;
    add_block(blk, BLOCK_LEN);
    clear_blk(); blk[0] = 1; blk[21] = -7;
    add_block(blk, BLOCK_LEN);
    drive(); drain("b2b");

    // 6: asynchronous reset with a partial block and a word pending on the output
    clear_blk(); blk[0] = 7; blk[15] = 2; blk[29] = 4;
    add_block(blk, 30);
    drive();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("case6_pre_valid", 64'(bus.out_valid), 64'd1);
    check("case6_pending",   64'(exp_q.size()), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("case6_rst_sym",   bus.out_sym,   0);
    check("case6_rst_dc",    bus.out_dc,    0);
    check("case6_rst_last",  bus.out_last,  0);
    check("case6_rst_valid", bus.out_valid, 0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    clear_blk(); blk[0] = 5;
    add_block(blk, BLOCK_LEN); drive(); drain("case6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
